servo_meas_sched: RTL
=====================

Name: servo_meas_sched

Overview:
- Per-frame sequencer and PWM output stage for the pan/tilt servo loop.
- On each vsync it reads the servo position feedback channels (AUX A = pan/x, AUX B = tilt/y) from the XADC over the DRP port, one at a time. It then presents the latched measurements and a valid pulse to the x/y threshold calculators.
- It turns their 15-bit microsecond thresholds into two 50 Hz servo PWM outputs, with glitch-free updates only at period boundaries.

Parameters:
- AUX_A_ADDR, 7'h1E, DRP address of pan feedback channel.
- AUX_B_ADDR, 7'h16, DRP address of tilt feedback channel.
- TIMEOUT_CYC, 1023, clk cycles to wait for drp_drdy before abandoning a read.
- TICK_DIV, 100, clk cycles per microsecond tick (100 MHz clk).
- PERIOD_US, 20000, PWM period in microseconds.
- THR_MIN, 800, lower clamp on applied thresholds (µs).
- THR_MAX, 2150, upper clamp on applied thresholds (µs).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- vsync_in  in  1  frame sync from video domain; asynchronous, synchronized internally.
- drp_daddr  out  7  DRP address.
- drp_den  out  1  DRP enable, single-cycle pulse per read.
- drp_dwe  out  1  DRP write enable; constant 0.
- drp_do  in  16  DRP read data.
- drp_drdy  in  1  DRP read-data strobe.
- measured_aux_a  out  16  last good pan feedback sample.
- measured_aux_b  out  16  last good tilt feedback sample.
- meas_valid  out  1  one-cycle pulse when a frame's read sequence completes.
- meas_timeout  out  1  sticky; set on any DRP timeout, cleared only by rst.
- pwm_thres_x  in  15  requested pan high time, µs.
- pwm_thres_y  in  15  requested tilt high time, µs.
- pwm_x  out  1  pan servo PWM.
- pwm_y  out  1  tilt servo PWM.

Behaviour:
- Reset values:
  - drp_daddr=0, drp_den=0, drp_dwe=0 always.
  - measured_aux_a/b=0, meas_valid=0, meas_timeout=0.
  - pwm_x/pwm_y=0; shadow thresholds=1500; tick and period counters=0.
  - FSM=IDLE, pending=0, vsync sync flops=0.
- Vsync detection:
  - Path is vsync_in -> s1 -> s2 -> s3; edge = s2 & ~s3.
  - vsync_in sampled high at edge N gives edge high in cycle N+2.
- FSM states: IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, DONE.
  - IDLE: on edge or pending, go to REQ_A and clear pending.
  - REQ_A: drp_den=1 and drp_daddr=AUX_A_ADDR for exactly one cycle; timeout counter cleared; go to WAIT_A.
  - WAIT_A: on drp_drdy, measured_aux_a<=drp_do and go to REQ_B. Otherwise, if the counter reaches TIMEOUT_CYC, set meas_timeout, keep the old measured_aux_a, and go to REQ_B.
  - REQ_B / WAIT_B: same as REQ_A / WAIT_A with AUX_B_ADDR and measured_aux_b; exit to DONE.
  - DONE: meas_valid=1 for one cycle; return to IDLE.
  - drp_daddr holds its last value outside REQ states.
- Vsync while busy: an edge in any non-IDLE state sets pending (one deep; further edges are dropped). The next sequence starts on the cycle after returning to IDLE.
- drp_drdy outside WAIT states is ignored. drdy and timeout in the same cycle: drdy wins, no timeout flag.
- Read sequence latency with an immediate drdy: edge cycle E, den at E+1, drdy sampled at E+2, REQ_B den at E+3, drdy at E+4, meas_valid at E+5.
- PWM timing:
  - Tick counter counts 0..TICK_DIV-1.
  - us counter advances on tick wrap and runs 0..PERIOD_US-1.
  - When the us counter wraps to 0, the shadows load clamp(pwm_thres_x/y, THR_MIN, THR_MAX). Clamping uses a 15-bit unsigned compare.
  - Output rule: pwm_x <= (us_cnt < shadow_x) and pwm_y <= (us_cnt < shadow_y), registered, one cycle latency.
  - Input changes mid-period have no effect until the next period.
- PWM and FSM run independently. rst mid-sequence aborts any DRP read, returns to IDLE, and drops pending.

Test Plan:
- Reset, then vsync_in rising; DRP model returns 16'h8000 for A and 16'h4000 for B with drdy 1 cycle after den -> two den pulses at addresses 7'h1E then 7'h16; measured_aux_a=16'h8000, measured_aux_b=16'h4000; one meas_valid pulse 5 cycles after edge detection.
- DRP model never asserts drdy for A -> after 1023 wait cycles, meas_timeout=1; measured_aux_a unchanged; B read proceeds; meas_valid still pulses.
- Three vsync edges during a slow (200-cycle drdy) sequence -> exactly one extra sequence runs immediately after DONE; total of 2 meas_valid pulses.
- pwm_thres_x=1500, pwm_thres_y=3000 -> pwm_x high 150000 cycles of each 2000000; pwm_y clamped to high for 215000 cycles; pwm_thres_x=100 gives 80000 cycles.
- Change pwm_thres_x from 1000 to 2000 at us_cnt=500 -> current period high for 1000 µs; next period high for 2000 µs; no glitch pulse.
- Assert rst during WAIT_B -> next cycle drp_den=0, meas_valid=0, all outputs at reset values; a fresh vsync then runs a full sequence.

Source files
------------

// File: rtl/servo_meas_sched.sv
// servo_meas_sched: per-frame XADC DRP feedback reads plus 50 Hz pan/tilt servo PWM
module servo_meas_sched #(
  parameter logic [6:0] AUX_A_ADDR  = 7'h1E,
  parameter logic [6:0] AUX_B_ADDR  = 7'h16,
  parameter int         TIMEOUT_CYC = 1023,
  parameter int         TICK_DIV    = 100,
  parameter int         PERIOD_US   = 20000,
  parameter int         THR_MIN     = 800,
  parameter int         THR_MAX     = 2150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic [15:0] measured_aux_a,
  output logic [15:0] measured_aux_b,
  output logic        meas_valid,
  output logic        meas_timeout,
  input  logic [14:0] pwm_thres_x,
  input  logic [14:0] pwm_thres_y,
  output logic        pwm_x,
  output logic        pwm_y
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, DONE} state_t;
  state_t state, state_nx;
  logic s1, s2, s3, vs_edge, pending, waiting, to_hit;
  logic [CW-1:0] to_cnt;
  logic [6:0] addr_q;
  logic [TW-1:0] tick_cnt;
  logic [14:0] us_cnt, shadow_x, shadow_y;
  logic tick_wrap, us_wrap;
  function automatic logic [14:0] clamp(input logic [14:0] t);
    return t < 15'(THR_MIN) ? 15'(THR_MIN) : t > 15'(THR_MAX) ? 15'(THR_MAX) : t;
  endfunction
  assign vs_edge   = s2 & ~s3;
  assign waiting   = state == WAIT_A || state == WAIT_B;
  assign to_hit    = to_cnt == CW'(TIMEOUT_CYC - 1);
  assign drp_den   = state == REQ_A || state == REQ_B;
  assign drp_daddr = state == REQ_A ? AUX_A_ADDR : state == REQ_B ? AUX_B_ADDR : addr_q;
  assign drp_dwe   = 1'b0;
  assign meas_valid = state == DONE;
  assign tick_wrap = tick_cnt == TW'(TICK_DIV - 1);
  assign us_wrap   = tick_wrap && us_cnt == 15'(PERIOD_US - 1);
  // three-flop synchronizer for the asynchronous frame sync
  always_ff @(posedge clk)
    if (rst) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {vsync_in, s1, s2};
  // read sequencer state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: each wait ends on drdy or on the timeout, whichever comes first
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (vs_edge || pending) ? REQ_A : IDLE;
      REQ_A:   state_nx = WAIT_A;
      WAIT_A:  state_nx = (drp_drdy || to_hit) ? REQ_B : WAIT_A;
      REQ_B:   state_nx = WAIT_B;
      WAIT_B:  state_nx = (drp_drdy || to_hit) ? DONE : WAIT_B;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // measurement capture, timeout counter, sticky timeout flag and one-deep pending frame
  always_ff @(posedge clk)
    if (rst) begin
      addr_q         <= '0;
      pending        <= 1'b0;
      to_cnt         <= '0;
      measured_aux_a <= '0;
      measured_aux_b <= '0;
      meas_timeout   <= 1'b0;
    end else begin
      addr_q         <= drp_daddr;
      pending        <= state == IDLE ? 1'b0 : pending | vs_edge;
      to_cnt         <= drp_den ? '0 : waiting ? to_cnt + 1'b1 : to_cnt;
      measured_aux_a <= (state == WAIT_A && drp_drdy) ? drp_do : measured_aux_a;
      measured_aux_b <= (state == WAIT_B && drp_drdy) ? drp_do : measured_aux_b;
      meas_timeout   <= meas_timeout | (waiting & ~drp_drdy & to_hit);
    end
  // microsecond timebase; shadows reload only at the period boundary so pulses never glitch
  always_ff @(posedge clk)
    if (rst) begin
      tick_cnt <= '0;
      us_cnt   <= '0;
      shadow_x <= 15'd1500;
      shadow_y <= 15'd1500;
      pwm_x    <= 1'b0;
      pwm_y    <= 1'b0;
    end else begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
      us_cnt   <= us_wrap ? '0 : tick_wrap ? us_cnt + 1'b1 : us_cnt;
      shadow_x <= us_wrap ? clamp(pwm_thres_x) : shadow_x;
      shadow_y <= us_wrap ? clamp(pwm_thres_y) : shadow_y;
      pwm_x    <= us_cnt < shadow_x;
      pwm_y    <= us_cnt < shadow_y;
    end
endmodule
